// File: rtl/group_gp_if.sv
// Operand and group generate/propagate handshake bundle
// between the adder front end and the prefix tree.
interface group_gp_if #(
    parameter int INPUTSIZE = 32,
    parameter int TREESIZE  = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [INPUTSIZE-1:0]  a;
    logic [INPUTSIZE-1:0]  b;
    logic                  cin;
    logic                  out_valid;
    logic                  out_ready;
    logic [2*TREESIZE-1:0] gp_o;
    logic [INPUTSIZE-1:0]  g_bit_o;
    logic [INPUTSIZE-1:0]  p_bit_o;
    logic                  cin_o;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, gp_o, g_bit_o, p_bit_o, cin_o
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, gp_o, g_bit_o, p_bit_o, cin_o
    );
endinterface

// File: rtl/group_gp_stage.sv
// Registered per-group (G,P) pre-processing stage ahead of the
// prefix tree, with a 2-entry skid buffer on the output handshake.
module group_gp_stage #(
    parameter int INPUTSIZE = 32,
    parameter int GROUPSIZE = 4
) (
    input  logic       clk,
    input  logic       rst,
    group_gp_if.slave  bus
);
    localparam int TREESIZE = INPUTSIZE / GROUPSIZE;

    typedef struct packed {
        logic [2*TREESIZE-1:0] gp;
        logic [INPUTSIZE-1:0]  g;
        logic [INPUTSIZE-1:0]  p;
        logic                  cin;
    } slot_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e state_q, state_d;
    slot_t  main_q, main_d;
    slot_t  skid_q, skid_d;
    slot_t  new_slot;
    logic   accept;
    logic   consume;

    // Seeding group 0's ripple with cin folds P_0 & cin into G_0.
    always_comb begin : gp_calc
        logic gg;
        logic pp;
        new_slot     = '0;
        new_slot.g   = bus.a & bus.b;
        new_slot.p   = bus.a ^ bus.b;
        new_slot.cin = bus.cin;
        for (int i = 0; i < TREESIZE; i++) begin
            gg = (i == 0) ? bus.cin : 1'b0;
            pp = 1'b1;
            for (int k = 0; k < GROUPSIZE; k++) begin
                gg = new_slot.g[i*GROUPSIZE+k]
                   | (new_slot.p[i*GROUPSIZE+k] & gg);
                pp = pp & new_slot.p[i*GROUPSIZE+k];
            end
            new_slot.gp[2*i+1] = gg;
            new_slot.gp[2*i]   = pp;
        end
    end

    assign bus.in_ready  = (state_q != FULL);
    assign bus.out_valid = (state_q != EMPTY);
    assign bus.gp_o      = main_q.gp;
    assign bus.g_bit_o   = main_q.g;
    assign bus.p_bit_o   = main_q.p;
    assign bus.cin_o     = main_q.cin;

    assign accept  = bus.in_valid & bus.in_ready;
    assign consume = bus.out_valid & bus.out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    main_d  = new_slot;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (accept && consume) begin
                    main_d = new_slot;
                end else if (accept) begin
                    skid_d  = new_slot;
                    state_d = FULL;
                end else if (consume) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (consume) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end
endmodule

// File: tb/tb_group_gp_stage.sv
// Scoreboard bench for group_gp_stage: directed handshake
// corner cases plus a random stream with output stalls.
module tb_group_gp_stage;
    localparam int IS = 32;
    localparam int GS = 4;
    localparam int TS = IS / GS;

    typedef struct packed {
        logic [2*TS-1:0] gp;
        logic [IS-1:0]   g;
        logic [IS-1:0]   p;
        logic            cin;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    group_gp_if #(.INPUTSIZE(IS), .TREESIZE(TS)) bus ();

    group_gp_stage #(.INPUTSIZE(IS), .GROUPSIZE(GS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    logic acc_seen;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Direct definition: G_i = OR_k (g_k & AND_{j>k} p_j).
    function automatic exp_t model(input logic [IS-1:0] a,
                                   input logic [IS-1:0] b,
                                   input logic c);
        exp_t e;
        logic t, gg, pp;
        e     = '0;
        e.g   = a & b;
        e.p   = a ^ b;
        e.cin = c;
        for (int i = 0; i < TS; i++) begin
            gg = 1'b0;
            pp = 1'b1;
            for (int k = 0; k < GS; k++) begin
                t = e.g[i*GS+k];
                for (int j = k + 1; j < GS; j++) t = t & e.p[i*GS+j];
                gg = gg | t;
                pp = pp & e.p[i*GS+k];
            end
            if (i == 0) gg = gg | (pp & c);
            e.gp[2*i+1] = gg;
            e.gp[2*i]   = pp;
        end
        return e;
    endfunction

    // Decide handshakes at the negedge; inputs are stable until the next posedge.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        acc_seen = 1'b0;
        if (rst) begin
            q.delete();
        end else begin
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(model(bus.a, bus.b, bus.cin));
                acc_seen = 1'b1;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    check("sb_underflow", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    check("sb_gp",  64'(bus.gp_o),    64'(e.gp));
                    check("sb_g",   64'(bus.g_bit_o), 64'(e.g));
                    check("sb_p",   64'(bus.p_bit_o), 64'(e.p));
                    check("sb_cin", 64'(bus.cin_o),   64'(e.cin));
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [IS-1:0] a, input logic [IS-1:0] b,
                         input logic c);
        bus.a        = a;
        bus.b        = b;
        bus.cin      = c;
        bus.in_valid = 1'b1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ov"},  64'(bus.out_valid), 64'd0);
        check({tag, "_ir"},  64'(bus.in_ready),  64'd1);
        check({tag, "_gp"},  64'(bus.gp_o),      64'd0);
        check({tag, "_g"},   64'(bus.g_bit_o),   64'd0);
        check({tag, "_p"},   64'(bus.p_bit_o),   64'd0);
        check({tag, "_cin"}, 64'(bus.cin_o),     64'd0);
    endtask

    initial begin
        exp_t e1;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;
        check_zero("reset");

        // All-propagate operands with carry-in
        bus.out_ready = 1'b1;
        drive(32'hFFFF_FFFF, 32'h0, 1'b1);
        cycle();
        bus.in_valid = 1'b0;
        check("t1_ov", 64'(bus.out_valid), 64'd1);
        check("t1_gp", 64'(bus.gp_o), 64'h5557);
        check("t1_p",  64'(bus.p_bit_o), 64'hFFFF_FFFF);
        check("t1_g",  64'(bus.g_bit_o), 64'h0);
        cycle();

        drive(32'h0000_000F, 32'h0000_0001, 1'b0);
        cycle();
        bus.in_valid = 1'b0;
        check("t2_gp", 64'(bus.gp_o), 64'h0002);
        check("t2_g",  64'(bus.g_bit_o), 64'h1);
        check("t2_p",  64'(bus.p_bit_o), 64'hE);
        cycle();
        check("t2_drain", 64'(bus.out_valid), 64'd0);

        // Stall: fill main and skid, third request must wait
        bus.out_ready = 1'b0;
        drive(32'h1234_5678, 32'h0F0F_F0F0, 1'b1);
        cycle();
        drive(32'hDEAD_BEEF, 32'h2152_4111, 1'b0);
        e1 = model(32'hDEAD_BEEF, 32'h2152_4111, 1'b0);
        cycle();
        check("t3_full_ir", 64'(bus.in_ready), 64'd0);
        drive(32'h8000_0001, 32'h8000_0001, 1'b1);
        cycle();
        check("t3_noacc", 64'(acc_seen), 64'd0);
        check("t3_hold_ov", 64'(bus.out_valid), 64'd1);
        bus.out_ready = 1'b1;
        cycle();
        check("t4_noacc", 64'(acc_seen), 64'd0);
        check("t4_ir", 64'(bus.in_ready), 64'd1);
        check("t4_skid_gp", 64'(bus.gp_o), 64'(e1.gp));
        cycle();
        check("t3_acc3", 64'(acc_seen), 64'd1);
        bus.in_valid = 1'b0;
        cycle();
        check("t3_empty", 64'(bus.out_valid), 64'd0);
        check("t3_sb_empty", 64'(q.size()), 64'd0);

        // Reset while FULL
        bus.out_ready = 1'b0;
        drive(32'hAAAA_5555, 32'h5555_AAAA, 1'b1);
        cycle();
        drive(32'h0F0F_0F0F, 32'h0101_0101, 1'b0);
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        check_zero("t5_rst");
        drive(32'h0000_00FF, 32'h0000_0001, 1'b0);
        cycle();
        bus.in_valid = 1'b0;
        check("t5_ov", 64'(bus.out_valid), 64'd1);
        bus.out_ready = 1'b1;
        cycle();

        // Random stream; upstream holds data while not accepted
        drive($urandom, $urandom, 1'($urandom));
        for (int n = 0; n < 600; n++) begin
            bus.out_ready = ($urandom_range(0, 2) != 0);
            cycle();
            if (acc_seen || !bus.in_valid) begin
                bus.a        = $urandom;
                bus.b        = $urandom;
                if (n % 7 == 0) bus.b = ~bus.a;
                bus.cin      = 1'($urandom);
                bus.in_valid = ($urandom_range(0, 3) != 0);
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int n = 0; n < 4; n++) cycle();
        check("rand_drain_ov", 64'(bus.out_valid), 64'd0);
        check("rand_sb_empty", 64'(q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
